rf_wb_ctrl: RTL and testbench
=============================

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of write-queue entries (power of two, 2..16).
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 mem_valid  input  1  Load-unit writeback request.
REQ-005 mem_ready  output  1  Load-unit request accepted this cycle when mem_valid=1.
REQ-006 mem_wa  input  5  Load destination register.
REQ-007 mem_wd  input  32  Load data.
REQ-008 alu_valid  input  1  ALU writeback request.
REQ-009 alu_ready  output  1  ALU request accepted this cycle when alu_valid=1.
REQ-010 alu_wa  input  5  ALU destination register.
REQ-011 alu_wd  input  32  ALU result.
REQ-012 RFWE  output  1  Register-file write enable, registered.
REQ-013 RFWA  output  5  Register-file write address, registered.
REQ-014 RFWD  output  32  Register-file write data, registered.
REQ-015 q1_addr, q2_addr  input  5 each  Operand lookup addresses from decode.
REQ-016 q1_hit, q2_hit  output  1 each  Lookup matches a pending write.
REQ-017 q1_data, q2_data  output  32 each  Forwarded data of youngest matching pending write.
REQ-018 pending  output  32  Bit r set while a write to register r is queued or on RFWE.

Function
REQ-019 Queue is FIFO of {wa, wd}; count 0..DEPTH; free = DEPTH - count, using registered count only (no same-cycle credit from pop).
REQ-020 mem_ready = (free >= 1).
REQ-021 alu_ready = (free >= 2) or (free >= 1 and mem_valid = 0).
REQ-022 Same-cycle accept of both: mem entry enqueued older than alu entry.
REQ-023 Request with wa = 0 is accepted per ready rules but not enqueued; never produces RFWE, never sets pending.
REQ-024 Each cycle with count > 0: head popped at clock edge into RFWE/RFWA/RFWD (RFWE=1); count = 0: RFWE=0 next cycle, RFWA/RFWD hold.
REQ-025 Push and pop in same cycle: count changes by pushes minus 1; pointers wrap modulo DEPTH.
REQ-026 Latency: entry accepted at edge k into empty queue appears on RFWE after edge k+1; register file commits at edge k+2.
REQ-027 Sustained throughput one write per cycle; order on RFWE equals acceptance order.
REQ-028 Lookup combinational: hit if q_addr != 0 and matches any queued entry or (RFWE=1 and RFWA); data from youngest match (tail-most queue entry, else output stage).
REQ-029 q_addr = 0: hit = 0, data = 0.
REQ-030 pending combinational from queue contents and output stage; bit 0 always 0.
REQ-031 Full queue (count = DEPTH): both readies 0; no entry lost or overwritten.

Reset
REQ-032 rst=1 asynchronously: count=0, pointers=0, RFWE=0, RFWA=0, RFWD=0, pending=0, q*_hit=0; mem_ready=alu_ready=1 after release.
REQ-033 Reset mid-operation discards all queued and in-flight writes; no RFWE pulse during or after reset until new accept.

Verification
REQ-034 Single ALU write r5=0x1234 into empty queue -> RFWE=1, RFWA=5, RFWD=0x1234 exactly one cycle after accept; pending[5] high for 2 cycles.
REQ-035 Same cycle mem r3=0xA, alu r3=0xB -> q1_addr=3 returns hit, 0xB; RFWE order r3=0xA then r3=0xB.
REQ-036 Stall pop-side not possible, so fill with DEPTH=4 via both-valid bursts -> readies drop per REQ-020/021, 4+ consecutive RFWE pulses, no loss.
REQ-037 alu_wa=0, alu_wd=0xFFFF -> alu_ready=1, no RFWE, pending=0, q1_addr=0 gives hit=0.
REQ-038 Assert rst with 3 entries queued -> RFWE=0 immediately, pending=0, no later writes of discarded entries.
REQ-039 Pointer wrap: 10 back-to-back single writes r1..r10 -> RFWE sequence r1..r10 with correct data.

Source files
------------

// File: rtl/rf_wb_ctrl.sv
// Writeback merge queue for load and ALU results feeding the register file.
// Pops one entry per cycle and forwards pending writes to decode.
module rf_wb_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_wa,
   input  logic [31:0] mem_wd,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_wa,
   input  logic [31:0] alu_wd,
   output logic        RFWE,
   output logic [4:0]  RFWA,
   output logic [31:0] RFWD,
   input  logic [4:0]  q1_addr,
   input  logic [4:0]  q2_addr,
   output logic        q1_hit,
   output logic        q2_hit,
   output logic [31:0] q1_data,
   output logic [31:0] q2_data,
   output logic [31:0] pending
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [4:0]    q_wa [DEPTH];
   logic [31:0]   q_wd [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] free;
   logic          mem_push;
   logic          alu_push;
   logic          pop;
   logic [1:0]    pushes;
   logic [PW-1:0] alu_slot;

   assign free      = CW'(DEPTH) - count;
   assign mem_ready = (free != '0);
   assign alu_ready = (free >= CW'(2)) || ((free != '0) && !mem_valid);

   // Register 0 writes are handshaken but dropped before the queue.
   assign mem_push = mem_valid && mem_ready && (mem_wa != 5'd0);
   assign alu_push = alu_valid && alu_ready && (alu_wa != 5'd0);
   assign pop      = (count != '0);
   assign pushes   = {1'b0, mem_push} + {1'b0, alu_push};
   assign alu_slot = tail + PW'(mem_push);

   always_ff @(posedge clk) begin
      if (mem_push) begin
         q_wa[tail] <= mem_wa;
         q_wd[tail] <= mem_wd;
      end
      if (alu_push) begin
         q_wa[alu_slot] <= alu_wa;
         q_wd[alu_slot] <= alu_wd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         RFWE  <= 1'b0;
         RFWA  <= 5'd0;
         RFWD  <= 32'd0;
      end else begin
         tail  <= tail + PW'(pushes);
         count <= count + CW'(pushes) - CW'(pop);
         if (pop) begin
            head <= head + PW'(1);
            RFWE <= 1'b1;
            RFWA <= q_wa[head];
            RFWD <= q_wd[head];
         end else begin
            RFWE <= 1'b0;
         end
      end
   end

   // Later matches override earlier ones, so the youngest write wins.
   always_comb begin
      logic [PW-1:0] idx;
      q1_hit  = 1'b0;
      q1_data = 32'd0;
      q2_hit  = 1'b0;
      q2_data = 32'd0;
      pending = 32'd0;
      idx     = '0;
      if (RFWE) begin
         pending[RFWA] = 1'b1;
         if (RFWA == q1_addr) begin
            q1_hit  = 1'b1;
            q1_data = RFWD;
         end
         if (RFWA == q2_addr) begin
            q2_hit  = 1'b1;
            q2_data = RFWD;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count) begin
            pending[q_wa[idx]] = 1'b1;
            if (q_wa[idx] == q1_addr) begin
               q1_hit  = 1'b1;
               q1_data = q_wd[idx];
            end
            if (q_wa[idx] == q2_addr) begin
               q2_hit  = 1'b1;
               q2_data = q_wd[idx];
            end
         end
      end
      pending[0] = 1'b0;
      if (q1_addr == 5'd0) begin
         q1_hit  = 1'b0;
         q1_data = 32'd0;
      end
      if (q2_addr == 5'd0) begin
         q2_hit  = 1'b0;
         q2_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: expected writes queued at accept,
// checked in order as RFWE pulses appear.
module tb_rf_wb_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, alu_valid;
   logic        mem_ready, alu_ready;
   logic [4:0]  mem_wa, alu_wa;
   logic [31:0] mem_wd, alu_wd;
   logic        RFWE;
   logic [4:0]  RFWA;
   logic [31:0] RFWD;
   logic [4:0]  q1_addr, q2_addr;
   logic        q1_hit, q2_hit;
   logic [31:0] q1_data, q2_data;
   logic [31:0] pending;

   int errors = 0;
   int checks = 0;
   int mcount = 0;
   logic [36:0] sb [$];

   always #5 clk = ~clk;

   rf_wb_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_wa(mem_wa), .mem_wd(mem_wd),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_wa(alu_wa), .alu_wd(alu_wd),
      .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
      .q1_addr(q1_addr), .q2_addr(q2_addr),
      .q1_hit(q1_hit), .q2_hit(q2_hit),
      .q1_data(q1_data), .q2_data(q2_data),
      .pending(pending)
   );

   always @(negedge clk) begin
      logic [36:0] e;
      if (!rst && RFWE) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got r%0d=%h, none expected",
                     RFWA, RFWD);
         end else begin
            e = sb.pop_front();
            if ({RFWA, RFWD} !== e) begin
               errors++;
               $display("FAIL wb_order: got r%0d=%h, want r%0d=%h",
                        RFWA, RFWD, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic cycle(input logic mv, input logic [4:0] mwa,
                        input logic [31:0] mwd, input logic av,
                        input logic [4:0] awa, input logic [31:0] awd);
      int free;
      logic er_m, er_a, acc_m, acc_a;
      int np;
      mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
      alu_valid = av; alu_wa = awa; alu_wd = awd;
      @(negedge clk);
      free = DEPTH - mcount;
      er_m = (free >= 1);
      er_a = (free >= 2) || (free >= 1 && !mv);
      checks++;
      if (mem_ready !== er_m || alu_ready !== er_a) begin
         errors++;
         $display("FAIL ready: got mem=%b alu=%b, want mem=%b alu=%b",
                  mem_ready, alu_ready, er_m, er_a);
      end
      acc_m = mv && er_m;
      acc_a = av && er_a;
      np = 0;
      if (acc_m && mwa != 0) begin sb.push_back({mwa, mwd}); np++; end
      if (acc_a && awa != 0) begin sb.push_back({awa, awd}); np++; end
      @(posedge clk);
      mcount = mcount + np - ((mcount > 0) ? 1 : 0);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_valid = 0; alu_valid = 0;
      mem_wa = 0; mem_wd = 0; alu_wa = 0; alu_wd = 0;
      q1_addr = 0; q2_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (RFWE !== 1'b0 || RFWA !== 5'd0 || RFWD !== 32'd0
          || pending !== 32'd0 || q1_hit !== 1'b0 || q2_hit !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: we=%b wa=%0d wd=%h pend=%h hit=%b%b",
                  RFWE, RFWA, RFWD, pending, q1_hit, q2_hit);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b%b, want 11",
                  mem_ready, alu_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      q1_addr = 5;
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
      #1;
      checks++;
      if (RFWE !== 1'b0 || pending !== 32'h20 || q1_hit !== 1'b1
          || q1_data !== 32'h1234) begin
         errors++;
         $display("FAIL single_queued: we=%b pend=%h hit=%b d=%h",
                  RFWE, pending, q1_hit, q1_data);
      end
      idle();
      checks++;
      if (RFWE !== 1'b1 || RFWA !== 5'd5 || RFWD !== 32'h1234
          || pending !== 32'h20) begin
         errors++;
         $display("FAIL single_out: we=%b wa=%0d wd=%h pend=%h, want 1 5 1234 20",
                  RFWE, RFWA, RFWD, pending);
      end
      idle();
      checks++;
      if (RFWE !== 1'b0 || pending !== 32'd0 || q1_hit !== 1'b0) begin
         errors++;
         $display("FAIL single_done: we=%b pend=%h hit=%b",
                  RFWE, pending, q1_hit);
      end
   endtask

   task automatic test_same_reg();
      q1_addr = 3;
      q2_addr = 3;
      cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
      #1;
      checks++;
      if (q1_hit !== 1'b1 || q1_data !== 32'hB || q2_data !== 32'hB) begin
         errors++;
         $display("FAIL fwd_youngest: hit=%b d1=%h d2=%h, want 1 b b",
                  q1_hit, q1_data, q2_data);
      end
      idle();
      checks++;
      if (RFWD !== 32'hA || q1_data !== 32'hB || pending !== 32'h8) begin
         errors++;
         $display("FAIL fwd_mid: wd=%h d=%h pend=%h, want a b 8",
                  RFWD, q1_data, pending);
      end
      idle();
      checks++;
      if (RFWD !== 32'hB || q1_hit !== 1'b1 || q1_data !== 32'hB) begin
         errors++;
         $display("FAIL fwd_stage: wd=%h hit=%b d=%h, want b 1 b",
                  RFWD, q1_hit, q1_data);
      end
      idle();
      q1_addr = 0; q2_addr = 0;
   endtask

   task automatic test_fill();
      int streak = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 5'(10 + 2*i), 32'h100 + i, 1'b1, 5'(11 + 2*i),
               32'h200 + i);
         if (RFWE) streak++;
      end
      for (int i = 0; i < 12; i++) begin
         idle();
         if (RFWE) streak++;
      end
      checks++;
      if (streak !== 6) begin
         errors++;
         $display("FAIL fill_streak: got %0d writes, want 6", streak);
      end
   endtask

   task automatic test_zero_reg();
      q1_addr = 0;
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
      #1;
      checks++;
      if (pending !== 32'd0 || q1_hit !== 1'b0 || q1_data !== 32'd0) begin
         errors++;
         $display("FAIL zero_reg: pend=%h hit=%b d=%h, want 0 0 0",
                  pending, q1_hit, q1_data);
      end
      idle();
      checks++;
      if (RFWE !== 1'b0) begin
         errors++;
         $display("FAIL zero_reg_we: got %b, want 0", RFWE);
      end
   endtask

   task automatic test_reset_mid();
      q1_addr = 21;
      cycle(1'b1, 5'd20, 32'h51, 1'b1, 5'd21, 32'h52);
      cycle(1'b1, 5'd22, 32'h53, 1'b1, 5'd23, 32'h54);
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      mcount = 0;
      checks++;
      if (RFWE !== 1'b0 || pending !== 32'd0 || q1_hit !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: we=%b pend=%h hit=%b, want 0 0 0",
                  RFWE, pending, q1_hit);
      end
      mem_valid = 0; alu_valid = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) idle();
      checks++;
      if (RFWE !== 1'b0 || pending !== 32'd0) begin
         errors++;
         $display("FAIL reset_after: we=%b pend=%h", RFWE, pending);
      end
      q1_addr = 0;
   endtask

   task automatic test_back_to_back();
      int seen = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'hC000 + i);
         if (RFWE) seen++;
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         if (RFWE) seen++;
      end
      checks++;
      if (seen !== 10) begin
         errors++;
         $display("FAIL wrap_count: got %0d writes, want 10", seen);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_same_reg();
      test_fill();
      test_zero_reg();
      test_reset_mid();
      test_back_to_back();
      for (int i = 0; i < 4; i++) idle();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d writes never appeared", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
